// File: rtl/alu_result_monitor.sv
// Passive checker for a small ALU: recomputes each started command, scores the
// ALU's answer, counts lost commands and keeps a FWFT FIFO of scored records.
module alu_result_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        done_i,
  input  logic [15:0] result_i,
  input  logic        rd_en_i,
  output logic        rec_valid_o,
  output logic [35:0] rec_data_o,
  output logic [15:0] pass_cnt_o,
  output logic [15:0] fail_cnt_o,
  output logic [7:0]  timeout_cnt_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    op_q;
  logic [7:0]    a_q, b_q;
  logic          capture;
  logic [15:0]   pass_cnt_q, pass_cnt_d;
  logic [15:0]   fail_cnt_q, fail_cnt_d;
  logic [7:0]    timeout_cnt_q, timeout_cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [35:0]   mem_q [FIFO_DEPTH];
  logic [35:0]   rec_new;
  logic [15:0]   exp_res;
  logic          match;
  logic          push, pop, wr_en, full, empty;
  logic [TW-1:0] timer_inc;

  function automatic logic [15:0] expected_result(input logic [2:0] op,
                                                  input logic [7:0] a,
                                                  input logic [7:0] b);
    case (op)
      3'd1:    return {7'd0, {1'b0, a} + {1'b0, b}};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign exp_res   = expected_result(op_q, a_q, b_q);
  assign match     = (result_i == exp_res);
  assign rec_new   = {match, op_q, a_q, b_q, result_i};
  assign timer_inc = timer_q + TIMER_ONE;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    capture       = 1'b0;
    push          = 1'b0;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (op_i >= 3'd1) && (op_i <= 3'd4)) begin
          capture = 1'b1;
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_i) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          if (match) pass_cnt_d = sat_inc16(pass_cnt_q);
          else       fail_cnt_d = sat_inc16(fail_cnt_q);
        end else if (timer_inc == TIMEOUT_V) begin
          timer_d       = '0;
          timeout_cnt_d = sat_inc8(timeout_cnt_q);
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Record FIFO: one spare pointer bit separates full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd_en_i && !empty;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Command operands and FIFO storage carry no reset; empty masks stale data.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      op_q <= op_i;
      a_q  <= a_i;
      b_q  <= b_i;
    end
    if (wr_en && !reset_i) mem_q[wr_ptr_q[AW-1:0]] <= rec_new;
  end

  assign rec_valid_o   = !empty;
  assign rec_data_o    = empty ? 36'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign pass_cnt_o    = pass_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = (state_q == ST_WAIT);

endmodule

// File: tb/tb_alu_result_monitor.sv
// Scoreboard bench for alu_result_monitor: records are queued when a done is
// driven and compared when the DUT presents them at the FIFO head.
module tb_alu_result_monitor;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, done_i, rd_en_i;
  logic [2:0]  op_i;
  logic [7:0]  a_i, b_i;
  logic [15:0] result_i;
  logic        rec_valid_o, overflow_o, busy_o;
  logic [35:0] rec_data_o;
  logic [15:0] pass_cnt_o, fail_cnt_o;
  logic [7:0]  timeout_cnt_o;

  alu_result_monitor #(.FIFO_DEPTH(8), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .done_i(done_i), .result_i(result_i),
    .rd_en_i(rd_en_i), .rec_valid_o(rec_valid_o), .rec_data_o(rec_data_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .timeout_cnt_o(timeout_cnt_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] sb_q[$];
  int          m_pass = 0, m_fail = 0, m_to = 0;
  bit          m_ovf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expf(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] r;
    case (op)
      3'd1:    r = 16'(a) + 16'(b);
      3'd2:    r = {8'h00, a & b};
      3'd3:    r = {8'h00, a ^ b};
      3'd4:    r = 16'(a) * 16'(b);
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called just before the edge on which done_i (and possibly rd_en_i) is sampled.
  task automatic model_done(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] r, input bit pop);
    bit ok;
    if (pop && sb_q.size() > 0) begin
      chk("head_at_pop", rec_data_o, sb_q[0]);
      void'(sb_q.pop_front());
    end
    ok = (r == expf(op, a, b));
    if (ok) begin if (m_pass < 65535) m_pass++; end
    else    begin if (m_fail < 65535) m_fail++; end
    if (sb_q.size() < 8) sb_q.push_back({ok, op, a, b, r});
    else                 m_ovf = 1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pass"}, pass_cnt_o, m_pass);
    chk({tag, "_fail"}, fail_cnt_o, m_fail);
    chk({tag, "_tmo"}, timeout_cnt_o, m_to);
    chk({tag, "_ovf"}, overflow_o, m_ovf);
    chk({tag, "_valid"}, rec_valid_o, sb_q.size() > 0);
    chk({tag, "_data"}, rec_data_o, (sb_q.size() > 0) ? sb_q[0] : 36'h0);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int delay, input logic [15:0] r, input bit pop);
    int nb = 0;
    start_i = 1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 0; op_i = 0;
    for (int i = 1; i < delay; i++) begin
      if (busy_o) nb++;
      tick();
    end
    if (busy_o) nb++;
    done_i = 1; result_i = r; rd_en_i = pop;
    model_done(op, a, b, r, pop);
    tick();
    done_i = 0; rd_en_i = 0;
    chk("busy_cycles", nb, delay);
    chk("busy_after", busy_o, 0);
    check_state("cmd");
  endtask

  task automatic run_timeout(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input bit full_check);
    int nb = 0;
    start_i = 1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 0; op_i = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) break;
      nb++;
      tick();
    end
    if (m_to < 255) m_to++;
    chk("tmo_busy_cycles", nb, 15);
    if (full_check) check_state("tmo");
    else chk("tmo_cnt", timeout_cnt_o, m_to);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      rd_en_i = 1;
      chk("drain_valid", rec_valid_o, 1);
      chk("drain_data", rec_data_o, sb_q[0]);
      void'(sb_q.pop_front());
      tick();
    end
    rd_en_i = 0;
    check_state("drained");
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rop;
    reset_i = 1; start_i = 1; op_i = 3'd1; a_i = 8'h01; b_i = 8'h02;
    done_i = 0; result_i = 0; rd_en_i = 0;
    tick(); tick();
    reset_i = 0; start_i = 0; op_i = 0;
    chk("reset_busy", busy_o, 0);
    check_state("reset");

    run_cmd(3'd1, 8'h12, 8'h34, 1, 16'h0046, 0);
    chk("add_record", rec_data_o, 36'h9_1234_0046);
    drain();
    run_cmd(3'd4, 8'hFF, 8'hFF, 3, 16'hFE01, 0);
    drain();
    run_cmd(3'd3, 8'hF0, 8'h0F, 2, 16'h0000, 0);
    chk("xor_record", rec_data_o, 36'h3_F00F_0000);
    drain();
    run_cmd(3'd1, 8'hFF, 8'h01, 1, 16'h0100, 0);
    run_cmd(3'd2, 8'hA5, 8'h3C, 2, 16'h0024, 0);
    run_cmd(3'd1, 8'h80, 8'h80, 1, 16'h0000, 0);
    drain();

    run_timeout(3'd1, 8'h01, 8'h02, 1);

    start_i = 1; op_i = 3'd0; tick();
    op_i = 3'd5; tick();
    op_i = 3'd7; tick();
    start_i = 0; op_i = 0; done_i = 1; result_i = 16'h0046; tick();
    done_i = 0; rd_en_i = 1; tick();
    rd_en_i = 0;
    chk("ignored_busy", busy_o, 0);
    check_state("ignored");

    for (int i = 0; i < 9; i++) begin
      rop = 3'(1 + i % 4); ra = 8'($urandom); rb = 8'($urandom);
      run_cmd(rop, ra, rb, 1 + i % 3, expf(rop, ra, rb), 0);
    end
    chk("fill_ovf", overflow_o, 1);
    chk("fill_pass", pass_cnt_o, m_pass);
    rop = 3'd4; ra = 8'h0C; rb = 8'h0D;
    run_cmd(rop, ra, rb, 2, expf(rop, ra, rb) ^ 16'h0001, 1);
    drain();

    start_i = 1; op_i = 3'd2; a_i = 8'hCC; b_i = 8'hAA;
    tick();
    chk("held_busy", busy_o, 1);
    done_i = 1; result_i = expf(3'd2, 8'hCC, 8'hAA);
    model_done(3'd2, 8'hCC, 8'hAA, result_i, 0);
    tick();
    done_i = 0;
    chk("held_gap", busy_o, 0);
    tick();
    chk("held_recapture", busy_o, 1);
    done_i = 1; start_i = 0;
    model_done(3'd2, 8'hCC, 8'hAA, result_i, 0);
    tick();
    done_i = 0; op_i = 0;
    chk("held_idle", busy_o, 0);
    check_state("held");

    start_i = 1; op_i = 3'd4; a_i = 8'h10; b_i = 8'h10;
    tick();
    start_i = 0; op_i = 0;
    tick();
    reset_i = 1; done_i = 1; result_i = 16'h0100;
    tick();
    reset_i = 0;
    sb_q.delete(); m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0;
    chk("rst_wait_busy", busy_o, 0);
    check_state("rst_wait");
    tick();
    done_i = 0;
    chk("late_done_busy", busy_o, 0);
    check_state("late_done");

    for (int i = 0; i < 256; i++) run_timeout(3'd3, 8'h11, 8'h22, 0);
    chk("tmo_saturated", timeout_cnt_o, 8'hFF);
    run_cmd(3'd1, 8'h12, 8'h34, 1, 16'h0046, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
